pdp1_mem_arbiter: RTL and testbench

Shares the single CPU-side port (port A) of the 4096 x 18-bit PDP-1 main RAM between two requesters: the PDP-1 CPU and a secondary master such as the tape loader or debug console. The CPU normally has priority; a starvation counter guarantees the secondary master forward progress. The block is pipelined and accepts one access per cycle. It sits between the CPU/loader and `pdp1_main_ram`. Read data returns two cycles after acceptance.

---
 rtl/pdp1_mem_pkg.sv | 24 ++
 rtl/pdp1_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_pdp1_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdp1_mem_pkg.sv
// Shared widths and types for the PDP-1 main-memory arbiter.
package pdp1_mem_pkg;

    localparam int PDP1_ADDR_W = 12;
    localparam int PDP1_WORD_W = 18;

    typedef enum logic {
        MASTER_CPU = 1'b0,
        MASTER_SEC = 1'b1
    } pdp1_master_t;

    typedef enum logic [1:0] {
        CPU_PRI    = 2'd0,
        SEC_FORCED = 2'd1,
        SEC_LOCKED = 2'd2
    } pdp1_arb_state_t;

    // Tag riding alongside a read until its data appears on ram_q.
    typedef struct packed {
        logic         valid;
        pdp1_master_t master;
    } pdp1_rd_tag_t;

endpackage

// File: rtl/pdp1_mem_arbiter.sv
// Two-master arbiter for RAM port A: CPU priority with starvation relief for the secondary master.
// Optional burst lock for the secondary master is enabled by defining PDP1_ARB_LOCK_EN.
module pdp1_mem_arbiter
    import pdp1_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clock,
    input  logic                   reset,

    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [PDP1_ADDR_W-1:0] cpu_addr,
    input  logic [PDP1_WORD_W-1:0] cpu_wdata,
    output logic                   cpu_gnt,
    output logic                   cpu_rvalid,

    input  logic                   sec_req,
    input  logic                   sec_we,
    input  logic [PDP1_ADDR_W-1:0] sec_addr,
    input  logic [PDP1_WORD_W-1:0] sec_wdata,
    input  logic                   sec_lock,
    output logic                   sec_gnt,
    output logic                   sec_rvalid,

    output logic [PDP1_WORD_W-1:0] rdata,

    output logic [PDP1_ADDR_W-1:0] ram_address,
    output logic [PDP1_WORD_W-1:0] ram_data,
    output logic                   ram_wren,
    input  logic [PDP1_WORD_W-1:0] ram_q
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    pdp1_arb_state_t  state;
    pdp1_arb_state_t  state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_next;
    logic             cpu_acc;
    logic             sec_acc;
    pdp1_rd_tag_t     tag_s1;
    pdp1_rd_tag_t     tag_s2;

    // Grants are combinational so a requester can transfer in the same cycle it asks.
    always_comb begin
        cpu_gnt = 1'b0;
        sec_gnt = 1'b0;
        if (!reset) begin
            case (state)
                CPU_PRI: begin
                    cpu_gnt = cpu_req;
                    sec_gnt = sec_req & ~cpu_req;
                end
                SEC_FORCED: begin
                    sec_gnt = sec_req;
                    cpu_gnt = cpu_req & ~sec_req;
                end
                SEC_LOCKED: begin
                    sec_gnt = sec_req;
                end
                default: begin
                    cpu_gnt = 1'b0;
                    sec_gnt = 1'b0;
                end
            endcase
        end
    end

    // The lock exit path is always built; without the lock option it is simply never entered.
    always_comb begin
        state_next      = state;
        starve_cnt_next = starve_cnt;
        case (state)
            SEC_LOCKED: begin
                starve_cnt_next = '0;
                if (!sec_lock) begin
                    state_next = CPU_PRI;
                end
            end
            default: begin
                if (sec_gnt || !sec_req) begin
                    starve_cnt_next = '0;
                end else if (cpu_gnt && (starve_cnt != CNT_MAX)) begin
                    starve_cnt_next = starve_cnt + CNT_ONE;
                end
                if (sec_gnt) begin
                    state_next = CPU_PRI;
                end else if (starve_cnt_next == CNT_MAX) begin
                    state_next = SEC_FORCED;
                end
`ifdef PDP1_ARB_LOCK_EN
                if (sec_gnt && sec_lock) begin
                    state_next = SEC_LOCKED;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= CPU_PRI;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    assign cpu_acc = cpu_req & cpu_gnt;
    assign sec_acc = sec_req & sec_gnt;

    // Address and data hold their last value between accesses; only wren returns to 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            tag_s1      <= '0;
            tag_s2      <= '0;
        end else begin
            ram_wren <= 1'b0;
            if (sec_acc) begin
                ram_address <= sec_addr;
                ram_data    <= sec_wdata;
                ram_wren    <= sec_we;
            end else if (cpu_acc) begin
                ram_address <= cpu_addr;
                ram_data    <= cpu_wdata;
                ram_wren    <= cpu_we;
            end
            tag_s1.valid  <= (cpu_acc & ~cpu_we) | (sec_acc & ~sec_we);
            tag_s1.master <= sec_acc ? MASTER_SEC : MASTER_CPU;
            tag_s2        <= tag_s1;
        end
    end

    assign cpu_rvalid = tag_s2.valid & (tag_s2.master == MASTER_CPU);
    assign sec_rvalid = tag_s2.valid & (tag_s2.master == MASTER_SEC);
    assign rdata      = ram_q;

endmodule

// File: tb/tb_pdp1_mem_arbiter.sv
// Self-checking bench for pdp1_mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_pdp1_mem_arbiter;
    import pdp1_mem_pkg::*;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [11:0] cpu_addr;
    logic [17:0] cpu_wdata;
    logic        sec_req, sec_we, sec_lock, sec_gnt, sec_rvalid;
    logic [11:0] sec_addr;
    logic [17:0] sec_wdata;
    logic [17:0] rdata;
    logic [11:0] ram_address;
    logic [17:0] ram_data;
    logic        ram_wren;
    logic [17:0] ram_q;

    logic        pre_we;
    logic [11:0] pre_addr;
    logic [17:0] pre_data;
    logic [17:0] mem [0:4095];

    typedef struct {
        bit          valid;
        bit          we;
        bit          is_sec;
        logic [11:0] addr;
        logic [17:0] wdata;
        logic [17:0] rdata;
    } acc_t;

    int          total = 0;
    int          bad = 0;
    logic [17:0] gmem [0:4095];
    acc_t        acc_prev, p1, p2;
    bit          eg_cpu, eg_sec;
    int          consec;
    bit          owed, locked;
    logic [11:0] exp_addr;
    logic [17:0] exp_data;
    bit          exp_wren;

    pdp1_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .sec_req(sec_req), .sec_we(sec_we), .sec_addr(sec_addr), .sec_wdata(sec_wdata),
        .sec_lock(sec_lock), .sec_gnt(sec_gnt), .sec_rvalid(sec_rvalid),
        .rdata(rdata),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    // Behavioural RAM port A with a bench-only preload path.
    always @(posedge clock) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Predict grants from the arbitration rules, check them, then book the accepted access.
    task automatic evalGrants();
        #1;
        if (reset) begin
            eg_cpu = 0; eg_sec = 0;
        end else if (locked) begin
            eg_cpu = 0; eg_sec = sec_req;
        end else if (owed) begin
            eg_sec = sec_req; eg_cpu = cpu_req && !sec_req;
        end else begin
            eg_cpu = cpu_req; eg_sec = sec_req && !cpu_req;
        end
        checkOutput("cpu_gnt", 32'(cpu_gnt), 32'(eg_cpu));
        checkOutput("sec_gnt", 32'(sec_gnt), 32'(eg_sec));

        acc_prev.valid  = eg_cpu || eg_sec;
        acc_prev.is_sec = eg_sec;
        acc_prev.we     = eg_sec ? sec_we : cpu_we;
        acc_prev.addr   = eg_sec ? sec_addr : cpu_addr;
        acc_prev.wdata  = eg_sec ? sec_wdata : cpu_wdata;
        acc_prev.rdata  = '0;
        if (acc_prev.valid) begin
            if (acc_prev.we) gmem[acc_prev.addr] = acc_prev.wdata;
            else acc_prev.rdata = gmem[acc_prev.addr];
        end

        if (reset) begin
            consec = 0; owed = 0; locked = 0;
        end else if (locked) begin
            consec = 0;
            if (!sec_lock) locked = 0;
        end else if (eg_sec) begin
            consec = 0; owed = 0;
`ifdef PDP1_ARB_LOCK_EN
            if (sec_lock) locked = 1;
`endif
        end else if (!sec_req) begin
            consec = 0;
        end else if (eg_cpu) begin
            if (consec < LIMIT) consec++;
            if (consec == LIMIT) owed = 1;
        end
    endtask

    // Advance one clock and check the registered RAM side and read returns.
    task automatic tick();
        @(posedge clock);
        #1;
        if (reset) begin
            p1.valid = 0; p2.valid = 0;
            exp_addr = '0; exp_data = '0; exp_wren = 0;
        end else begin
            p2 = p1;
            p1 = acc_prev;
            p1.valid = acc_prev.valid && !acc_prev.we;
            exp_wren = acc_prev.valid && acc_prev.we;
            if (acc_prev.valid) begin
                exp_addr = acc_prev.addr;
                exp_data = acc_prev.wdata;
            end
        end
        checkOutput("cpu_rvalid", 32'(cpu_rvalid), 32'(p2.valid && !p2.is_sec));
        checkOutput("sec_rvalid", 32'(sec_rvalid), 32'(p2.valid && p2.is_sec));
        if (p2.valid) checkOutput("rdata", 32'(rdata), 32'(p2.rdata));
        checkOutput("ram_wren", 32'(ram_wren), 32'(exp_wren));
        checkOutput("ram_address", 32'(ram_address), 32'(exp_addr));
        checkOutput("ram_data", 32'(ram_data), 32'(exp_data));
    endtask

    task automatic cycle();
        evalGrants();
        tick();
    endtask

    // Random traffic that honours the hold-while-waiting rule for both masters.
    task automatic applyStimulus();
        if (!(cpu_req && !eg_cpu)) begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = ($urandom_range(0, 2) == 0);
            cpu_addr  = 12'($urandom_range(0, 15));
            cpu_wdata = 18'($urandom);
        end
        if (!(sec_req && !eg_sec)) begin
            sec_req   = ($urandom_range(0, 1) != 0);
            sec_we    = ($urandom_range(0, 2) == 0);
            sec_addr  = 12'($urandom_range(0, 15));
            sec_wdata = 18'($urandom);
        end
        sec_lock = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        reset = 1; pre_we = 0; pre_addr = '0; pre_data = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        sec_req = 0; sec_we = 0; sec_addr = '0; sec_wdata = '0; sec_lock = 0;
        consec = 0; owed = 0; locked = 0;
        acc_prev.valid = 0; p1.valid = 0; p2.valid = 0;
        exp_addr = '0; exp_data = '0; exp_wren = 0;

        // Preload while held in reset; grants and RAM-side outputs must sit at reset values.
        pre_we = 1;
        for (int i = 0; i < 18; i++) begin
            pre_addr = (i < 16) ? 12'(i) : ((i == 16) ? 12'o100 : 12'o7777);
            pre_data = (i == 16) ? 18'o777777 : 18'o0;
            gmem[pre_addr] = pre_data;
            cpu_req = (i % 2 == 0);
            sec_req = (i % 3 == 0);
            cycle();
        end
        pre_we = 0; cpu_req = 0; sec_req = 0;
        reset = 0;
        cycle();

        $display("[TB] CPU-only read of preloaded word");
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'o100;
        cycle();
        cpu_req = 0;
        cycle();
        checkOutput("t1_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        checkOutput("t1_rdata", 32'(rdata), 32'o777777);
        checkOutput("t1_sec_rvalid", 32'(sec_rvalid), 32'd0);
        cycle();

        $display("[TB] continuous contention");
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'd3;
        sec_req = 1; sec_we = 0; sec_addr = 12'd4; sec_lock = 0;
        for (int i = 0; i < 15; i++) begin
            evalGrants();
            checkOutput("t2_pattern", 32'(sec_gnt), 32'((i % 5) == 4));
            tick();
        end
        cpu_req = 0; sec_req = 0;
        cycle(); cycle();

        $display("[TB] write then read-after-write");
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'o7777; cpu_wdata = 18'o123456;
        cycle();
        checkOutput("t3_wren_n1", 32'(ram_wren), 32'd1);
        cpu_we = 0;
        cycle();
        checkOutput("t3_wren_n2", 32'(ram_wren), 32'd0);
        cpu_req = 0;
        cycle();
        checkOutput("t3_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        checkOutput("t3_rdata", 32'(rdata), 32'o123456);
        cycle();

        $display("[TB] reset with a read in flight");
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'd5;
        cycle();
        reset = 1; cpu_req = 0;
        cycle();
        checkOutput("t4_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        checkOutput("t4_ram_address", 32'(ram_address), 32'd0);
        reset = 0;
        cycle(); cycle();

        $display("[TB] secondary burst with lock request");
        sec_req = 1; sec_lock = 1; sec_we = 0; sec_addr = 12'd1;
        evalGrants();
        checkOutput("t5_first_sec", 32'(sec_gnt), 32'd1);
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'd2;
        for (int w = 0; w < 2; w++) begin
            evalGrants();
`ifdef PDP1_ARB_LOCK_EN
            checkOutput("t5_locked_cpu", 32'(cpu_gnt), 32'd0);
`else
            if (w == 0) checkOutput("t5_unlocked_cpu", 32'(cpu_gnt), 32'd1);
`endif
            tick();
        end
        sec_req = 0; sec_lock = 0;
        cycle();
        evalGrants();
        checkOutput("t5_cpu_after", 32'(cpu_gnt), 32'd1);
        tick();
        cpu_req = 0;
        cycle(); cycle();

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus();
            cycle();
        end
        cpu_req = 0; sec_req = 0; sec_lock = 0;
        for (int i = 0; i < 4; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
